// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared combinational ALU
// Round-robin by default; define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [3:0]        r0_ctrl,
  input  logic [4:0]        r0_shamt,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [3:0]        r1_ctrl,
  input  logic [4:0]        r1_shamt,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              s0_valid,
  input  logic              s0_ready,
  output logic [DATA_W-1:0] s0_data,
  output logic              s0_zero,
  output logic              s1_valid,
  input  logic              s1_ready,
  output logic [DATA_W-1:0] s1_data,
  output logic              s1_zero,
  output logic [15:0]       op_count
);

  logic              s0_valid_q, s0_valid_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s0_data_q, s0_data_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s0_zero_q, s0_zero_d;
  logic              s1_zero_q, s1_zero_d;
  logic [15:0]       op_count_q, op_count_d;
  logic              elig0, elig1, gnt0, gnt1;

`ifndef ALU_ARB_FIXED_PRIO_EN
  // 1 means requester 1 was granted last, so requester 0 wins the next tie.
  logic              last_q, last_d;
`endif

  always_comb begin
    elig0 = r0_valid & (~s0_valid_q | s0_ready);
    elig1 = r1_valid & (~s1_valid_q | s1_ready);
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt0  = elig0;
`else
    gnt0  = elig0 & (~elig1 | last_q);
`endif
    gnt1  = elig1 & ~gnt0;
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = 4'b0000;
    alu_shamt = 5'd0;
    if (gnt0) begin
      alu_a     = r0_a;
      alu_b     = r0_b;
      alu_ctrl  = r0_ctrl;
      alu_shamt = r0_shamt;
    end else if (gnt1) begin
      alu_a     = r1_a;
      alu_b     = r1_b;
      alu_ctrl  = r1_ctrl;
      alu_shamt = r1_shamt;
    end
  end

  // A new accept overrides a drain in the same cycle, keeping the slot full.
  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_data_d  = s0_data_q;
    s0_zero_d  = s0_zero_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_zero_d  = s1_zero_q;
    op_count_d = op_count_q;
    if (s0_valid_q & s0_ready) s0_valid_d = 1'b0;
    if (s1_valid_q & s1_ready) s1_valid_d = 1'b0;
    if (gnt0) begin
      s0_valid_d = 1'b1;
      s0_data_d  = alu_out;
      s0_zero_d  = alu_zero;
    end
    if (gnt1) begin
      s1_valid_d = 1'b1;
      s1_data_d  = alu_out;
      s1_zero_d  = alu_zero;
    end
    if (gnt0 | gnt1) op_count_d = op_count_q + 16'd1;
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    last_d = last_q;
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
      s0_zero_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_zero_q  <= 1'b0;
      op_count_q <= 16'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_data_q  <= s0_data_d;
      s0_zero_q  <= s0_zero_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_zero_q  <= s1_zero_d;
      op_count_q <= op_count_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;
  assign s0_valid = s0_valid_q;
  assign s0_data  = s0_data_q;
  assign s0_zero  = s0_zero_q;
  assign s1_valid = s1_valid_q;
  assign s1_data  = s1_data_q;
  assign s1_zero  = s1_zero_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural shared-ALU model
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       rv, rdy, sr, sv, sz;
  logic [1:0][31:0] ra, rb, sd;
  logic [1:0][3:0]  rc;
  logic [1:0][4:0]  rsh;
  logic [31:0]      alu_a, alu_b, alu_out;
  logic [3:0]       alu_ctrl;
  logic [4:0]       alu_shamt;
  logic             alu_zero;
  logic [15:0]      op_count;

  int tests = 0;
  int fails = 0;

  logic [1:0]       m_v;
  logic [1:0][31:0] m_d;
  int               m_last;
  logic [15:0]      m_cnt;
  logic [1:0]       obs_rdy;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(rv[0]), .r0_ready(rdy[0]), .r0_a(ra[0]), .r0_b(rb[0]), .r0_ctrl(rc[0]), .r0_shamt(rsh[0]),
    .r1_valid(rv[1]), .r1_ready(rdy[1]), .r1_a(ra[1]), .r1_b(rb[1]), .r1_ctrl(rc[1]), .r1_shamt(rsh[1]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_shamt(alu_shamt),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .s0_valid(sv[0]), .s0_ready(sr[0]), .s0_data(sd[0]), .s0_zero(sz[0]),
    .s1_valid(sv[1]), .s1_ready(sr[1]), .s1_data(sd[1]), .s1_zero(sz[1]),
    .op_count(op_count)
  );

  function automatic logic [31:0] alu_fn(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1111: return b << sh;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_out  = alu_fn(alu_ctrl, alu_a, alu_b, alu_shamt);
    alu_zero = (alu_out == 32'd0);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_v = 2'b00;
    m_d = '0;
    m_last = 1;
    m_cnt = 16'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rv = 2'b11;
    @(negedge clk);
    chk("ready_in_reset", {30'd0, rdy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rv = 2'b00;
    model_clear();
    chk("rst_s_valid", {30'd0, sv}, 32'd0);
    chk("rst_s0_data", sd[0], 32'd0);
    chk("rst_s1_data", sd[1], 32'd0);
    chk("rst_s_zero", {30'd0, sz}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
  endtask

  // One clock: check grant/ALU routing mid-cycle, advance the model, check responses after the edge.
  task automatic cycle();
    bit e[2];
    int win;
    @(negedge clk);
    for (int i = 0; i < 2; i++) e[i] = rv[i] && (!m_v[i] || sr[i]);
    if (e[0] && e[1]) win = FIXED ? 0 : 1 - m_last;
    else if (e[0])    win = 0;
    else if (e[1])    win = 1;
    else              win = -1;
    obs_rdy = rdy;
    chk("r0_ready", {31'd0, rdy[0]}, {31'd0, win == 0});
    chk("r1_ready", {31'd0, rdy[1]}, {31'd0, win == 1});
    if (win >= 0) begin
      chk("alu_a", alu_a, ra[win]);
      chk("alu_b", alu_b, rb[win]);
      chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, rc[win]});
    end else begin
      chk("alu_idle", {alu_a | alu_b, alu_ctrl, alu_shamt} == 0, 32'd1);
    end
    for (int i = 0; i < 2; i++) begin
      if (m_v[i] && sr[i]) m_v[i] = 1'b0;
      if (win == i) begin
        m_v[i] = 1'b1;
        m_d[i] = alu_fn(rc[i], ra[i], rb[i], rsh[i]);
      end
    end
    if (win >= 0) begin
      m_cnt = m_cnt + 16'd1;
      m_last = win;
    end
    @(posedge clk); #1;
    chk("s_valid", {30'd0, sv}, {30'd0, m_v});
    chk("op_count", {16'd0, op_count}, {16'd0, m_cnt});
    for (int i = 0; i < 2; i++) begin
      if (m_v[i]) begin
        chk(i == 0 ? "s0_data" : "s1_data", sd[i], m_d[i]);
        chk(i == 0 ? "s0_zero" : "s1_zero", {31'd0, sz[i]}, {31'd0, m_d[i] == 32'd0});
      end
    end
  endtask

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp_data;
    logic        exp_zero;
  } vec_t;

  vec_t tbl[10];
  logic [3:0] codes[8];

  initial begin
    tbl[0] = '{4'b0010, 32'd5,          32'd3,          5'd0,  32'd8,          1'b0};
    tbl[1] = '{4'b0000, 32'hF0F0_00FF,  32'h0FF0_0F0F,  5'd0,  32'h00F0_000F,  1'b0};
    tbl[2] = '{4'b0001, 32'hF000_0000,  32'h0000_000F,  5'd0,  32'hF000_000F,  1'b0};
    tbl[3] = '{4'b0110, 32'd7,          32'd7,          5'd0,  32'd0,          1'b1};
    tbl[4] = '{4'b0111, 32'd2,          32'd9,          5'd0,  32'd1,          1'b0};
    tbl[5] = '{4'b0111, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1,          1'b0};
    tbl[6] = '{4'b1100, 32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF,  1'b0};
    tbl[7] = '{4'b1111, 32'd0,          32'd1,          5'd31, 32'h8000_0000,  1'b0};
    tbl[8] = '{4'b0011, 32'd12,         32'd34,         5'd3,  32'd0,          1'b1};
    tbl[9] = '{4'b0010, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1};
    codes  = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0011};

    reset = 1'b1; rv = 2'b00; sr = 2'b11;
    ra = '0; rb = '0; rc = '0; rsh = '0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // First transaction: ADD 5+3 on requester 0.
    rv = 2'b01; ra[0] = 32'd5; rb[0] = 32'd3; rc[0] = 4'b0010;
    cycle();
    chk("first_ready", {31'd0, obs_rdy[0]}, 32'd1);
    chk("first_valid", {31'd0, sv[0]}, 32'd1);
    chk("first_data", sd[0], 32'd8);
    chk("first_zero", {31'd0, sz[0]}, 32'd0);
    chk("first_count", {16'd0, op_count}, 32'd1);

    for (int k = 0; k < 10; k++) begin
      rv = 2'b01; sr = 2'b11;
      rc[0] = tbl[k].ctrl; ra[0] = tbl[k].a; rb[0] = tbl[k].b; rsh[0] = tbl[k].sh;
      cycle();
      chk($sformatf("tbl%0d_data", k), sd[0], tbl[k].exp_data);
      chk($sformatf("tbl%0d_zero", k), {31'd0, sz[0]}, {31'd0, tbl[k].exp_zero});
    end

    // Both requesters contending with responses always consumed.
    do_reset();
    rv = 2'b11; sr = 2'b11;
    rc[0] = 4'b0110; ra[0] = 32'd7; rb[0] = 32'd7;
    rc[1] = 4'b0001; ra[1] = 32'd0; rb[1] = 32'd0;
    for (int k = 0; k < 4; k++) begin
      cycle();
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk($sformatf("tie_grant%0d", k), {30'd0, obs_rdy}, 32'd1);
`else
      chk($sformatf("tie_grant%0d", k), {30'd0, obs_rdy}, (k % 2 == 0) ? 32'd1 : 32'd2);
`endif
    end
    chk("tie_s0_zero", {31'd0, sz[0]}, 32'd1);
`ifndef ALU_ARB_FIXED_PRIO_EN
    chk("tie_s1_zero", {31'd0, sz[1]}, 32'd1);
`endif

    // Back-pressure on slot 1, then release with a same-cycle re-accept.
    do_reset();
    rv = 2'b10; sr = 2'b00;
    rc[1] = 4'b0010; ra[1] = 32'd1; rb[1] = 32'd1;
    cycle();
    rc[1] = 4'b0010; ra[1] = 32'd4; rb[1] = 32'd4;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_r1_ready", {31'd0, obs_rdy[1]}, 32'd0);
      chk("bp_s1_hold", sd[1], 32'd2);
    end
    sr = 2'b10;
    cycle();
    chk("rel_r1_ready", {31'd0, obs_rdy[1]}, 32'd1);
    chk("rel_s1_valid", {31'd0, sv[1]}, 32'd1);
    chk("rel_s1_data", sd[1], 32'd8);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rv = 2'($urandom);
      sr = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
      for (int i = 0; i < 2; i++) begin
        rc[i]  = codes[$urandom_range(7)];
        ra[i]  = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(15));
        rb[i]  = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(15));
        rsh[i] = 5'($urandom);
      end
      cycle();
    end

    // op_count wrap, then reset discards a pending response.
    do_reset();
    rv = 2'b01; sr = 2'b01; rc[0] = 4'b0010; ra[0] = 32'd1; rb[0] = 32'd2;
    repeat (65535) @(posedge clk);
    #1;
    chk("count_ffff", {16'd0, op_count}, 32'h0000_FFFF);
    @(posedge clk); #1;
    chk("count_wrap", {16'd0, op_count}, 32'd0);
    chk("pre_reset_s0_valid", {31'd0, sv[0]}, 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_ready", {30'd0, rdy}, 32'd0);
    @(posedge clk); #1;
    chk("reset_s0_valid", {31'd0, sv[0]}, 32'd0);
    chk("reset_count", {16'd0, op_count}, 32'd0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
